// File: rtl/reg_file_sb_pkg.sv
// Shared constants and helpers for the register file, its scoreboard and the
// decode/ALU blocks that size their operand buses from the same defaults.
package reg_file_sb_pkg;

   localparam int          DEF_DATA_W = 32;
   localparam int          DEF_ADDR_W = 5;
   localparam int          DEF_NUM_RD = 2;
   localparam int unsigned ZERO_IDX   = 32'd0;

   // True when the index names the hard-wired zero register in this build.
   function automatic logic is_zero_idx(input int unsigned idx, input int zero_reg);
      return (zero_reg != 0) && (idx == ZERO_IDX);
   endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Operand-read, write-back and issue bus between decode and the register file.
interface reg_file_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int CNT_W  = ADDR_W + 1
);
   logic [NUM_RD*ADDR_W-1:0] read_reg;
   logic [NUM_RD*DATA_W-1:0] read_data;
   logic [NUM_RD-1:0]        rd_pending;
   logic [ADDR_W-1:0]        write_reg;
   logic [DATA_W-1:0]        write_data;
   logic                     reg_write;
   logic                     issue_valid;
   logic [ADDR_W-1:0]        issue_reg;
   logic                     issue_ready;
   logic [CNT_W-1:0]         pending_count;
   logic                     idle;

   modport master (
      output read_reg, write_reg, write_data, reg_write, issue_valid, issue_reg,
      input  read_data, rd_pending, issue_ready, pending_count, idle
   );

   modport slave (
      input  read_reg, write_reg, write_data, reg_write, issue_valid, issue_reg,
      output read_data, rd_pending, issue_ready, pending_count, idle
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard: one bit per register, set on issue and cleared on
// write-back, with a running population count for the idle indication.
module reg_scoreboard
   import reg_file_sb_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int CNT_W    = ADDR_W + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  reg_write,
   input  logic [ADDR_W-1:0]     write_reg,
   input  logic                  issue_valid,
   input  logic [ADDR_W-1:0]     issue_reg,
   output logic                  issue_ready,
   output logic [2**ADDR_W-1:0]  pending,
   output logic [CNT_W-1:0]      pending_count,
   output logic                  idle
);
   localparam int               DEPTH   = 2**ADDR_W;
   localparam logic [DEPTH-1:0] ONE_HOT = {{(DEPTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [DEPTH-1:0] pending_r;
   logic [DEPTH-1:0] pending_nxt_s;
   logic [DEPTH-1:0] clr_mask_s;
   logic [DEPTH-1:0] set_mask_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_nxt_s;
   logic             ready_s;
   logic             clr_s;
   logic             set_s;
   logic             inc_s;
   logic             dec_s;

   // Issue handshake, set/clear masks and the count delta; set is applied after
   // clear so a retiring and re-issuing register stays pending.
   always_comb begin
      if (is_zero_idx(32'(issue_reg), ZERO_REG)) begin
         ready_s = 1'b1;
      end else begin
         ready_s = ~pending_r[issue_reg]
                 | ((BYPASS != 0) & reg_write & (write_reg == issue_reg));
      end
      clr_s       = reg_write & ~is_zero_idx(32'(write_reg), ZERO_REG);
      set_s       = issue_valid & ready_s & ~is_zero_idx(32'(issue_reg), ZERO_REG);
      inc_s       = set_s & ~pending_r[issue_reg];
      dec_s       = clr_s & pending_r[write_reg] & ~(set_s & (write_reg == issue_reg));
      clr_mask_s  = clr_s ? (ONE_HOT << write_reg) : {DEPTH{1'b0}};
      set_mask_s  = set_s ? (ONE_HOT << issue_reg) : {DEPTH{1'b0}};
      pending_nxt_s = (pending_r & ~clr_mask_s) | set_mask_s;
      case ({inc_s, dec_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pending vector and population count state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_r <= {DEPTH{1'b0}};
         count_r   <= {CNT_W{1'b0}};
      end else begin
         pending_r <= pending_nxt_s;
         count_r   <= count_nxt_s;
      end
   end

   assign issue_ready   = ready_s;
   assign pending       = pending_r;
   assign pending_count = count_r;
   assign idle          = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised multi-port register file with optional zero register, write
// bypass and an integrated write-pending scoreboard.
module reg_file_sb
   import reg_file_sb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int CNT_W    = ADDR_W + 1
) (
   input logic          clk,
   input logic          rst,
   reg_file_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] regs_r [DEPTH];
   logic [DEPTH-1:0]  pending_s;
   logic              we_s;

   assign we_s = bus.reg_write & ~is_zero_idx(32'(bus.write_reg), ZERO_REG);

   // Storage array; reset clears every entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (we_s) begin
         regs_r[bus.write_reg] <= bus.write_data;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] idx_s;
      logic              hit_s;
      logic [DATA_W-1:0] data_s;
      logic              pend_s;

      // Read mux: zero register, then same-cycle write forwarding, then array.
      always_comb begin
         idx_s = bus.read_reg[k*ADDR_W +: ADDR_W];
         hit_s = (BYPASS != 0) & bus.reg_write & (bus.write_reg == idx_s);
         if (is_zero_idx(32'(idx_s), ZERO_REG)) begin
            data_s = {DATA_W{1'b0}};
            pend_s = 1'b0;
         end else if (hit_s) begin
            data_s = bus.write_data;
            pend_s = 1'b0;
         end else begin
            data_s = regs_r[idx_s];
            pend_s = pending_s[idx_s];
         end
      end

      assign bus.read_data[k*DATA_W +: DATA_W] = data_s;
      assign bus.rd_pending[k]                 = pend_s;
   end

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS),
      .CNT_W    (CNT_W)
   ) u_sb (
      .clk           (clk),
      .rst           (rst),
      .reg_write     (bus.reg_write),
      .write_reg     (bus.write_reg),
      .issue_valid   (bus.issue_valid),
      .issue_reg     (bus.issue_reg),
      .issue_ready   (bus.issue_ready),
      .pending       (pending_s),
      .pending_count (bus.pending_count),
      .idle          (bus.idle)
   );

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: directed scenarios plus random traffic,
// checked against an array/popcount reference model.
module tb_reg_file_sb;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;
   localparam int CW = 6;
   localparam int DEPTH = 32;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  pend;
      logic        ready;
      logic [5:0]  count;
      logic        idle;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW)) bus ();

   reg_file_sb #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1), .CNT_W(CW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t        exp_q [$];
   logic [31:0] m_regs [DEPTH];
   bit          m_pend [DEPTH];
   int          total = 0;
   int          bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compare each presented response against the queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check("read_data0", {32'd0, bus.read_data[31:0]}, {32'd0, e.data[31:0]});
         check("read_data1", {32'd0, bus.read_data[63:32]}, {32'd0, e.data[63:32]});
         check("rd_pending", {62'd0, bus.rd_pending}, {62'd0, e.pend});
         check("issue_ready", {63'd0, bus.issue_ready}, {63'd0, e.ready});
         check("pending_count", {58'd0, bus.pending_count}, {58'd0, e.count});
         check("idle", {63'd0, bus.idle}, {63'd0, e.idle});
      end
   end

   task automatic cycle(input bit r, input int r0, input int r1, input bit we, input int wa,
                        input logic [31:0] wd, input bit iv, input int ia);
      exp_t e;
      int   cnt;
      int   idx;
      @(posedge clk);
      #2;
      rst             = r;
      bus.read_reg    = {5'(r1), 5'(r0)};
      bus.reg_write   = we;
      bus.write_reg   = 5'(wa);
      bus.write_data  = wd;
      bus.issue_valid = iv;
      bus.issue_reg   = 5'(ia);
      if (r) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
         end
      end
      e.data = 64'd0;
      e.pend = 2'b00;
      for (int k = 0; k < 2; k++) begin
         logic [31:0] v;
         bit          p;
         idx = (k == 0) ? r0 : r1;
         if (idx == 0) begin
            v = 32'd0; p = 1'b0;
         end else if (we && wa == idx) begin
            v = wd; p = 1'b0;
         end else begin
            v = m_regs[idx]; p = m_pend[idx];
         end
         if (k == 0) e.data[31:0] = v; else e.data[63:32] = v;
         e.pend[k] = p;
      end
      e.ready = (ia == 0) || !m_pend[ia] || (we && wa == ia);
      cnt = 0;
      for (int i = 0; i < DEPTH; i++) cnt += int'(m_pend[i]);
      e.count = 6'(cnt);
      e.idle  = (cnt == 0);
      exp_q.push_back(e);
      if (!r) begin
         if (we && wa != 0) begin
            m_regs[wa] = wd;
            m_pend[wa] = 1'b0;
         end
         if (iv && e.ready && ia != 0) m_pend[ia] = 1'b1;
      end
   endtask

   function automatic int rnd_idx();
      return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 9));
   endfunction

   initial begin
      bus.read_reg = '0; bus.reg_write = 1'b0; bus.write_reg = '0; bus.write_data = '0;
      bus.issue_valid = 1'b0; bus.issue_reg = '0;
      cycle(1, 0, 0, 0, 0, 32'd0, 0, 0);
      cycle(1, 0, 0, 0, 0, 32'd0, 0, 0);
      for (int i = 0; i < 16; i++) cycle(0, 2*i, 2*i+1, 0, 0, 32'd0, 0, 0);
      // bypass of a fresh write, then array read
      cycle(0, 5, 6, 1, 5, 32'hDEADBEEF, 0, 0);
      cycle(0, 5, 5, 0, 0, 32'd0, 0, 0);
      // zero register ignores writes and issues
      cycle(0, 0, 5, 1, 0, 32'h12345678, 1, 0);
      cycle(0, 0, 0, 0, 0, 32'd0, 0, 0);
      // issue r7, r9; re-issue r7 stalls; write+issue r7 together
      cycle(0, 7, 9, 0, 0, 32'd0, 1, 7);
      cycle(0, 7, 9, 0, 0, 32'd0, 1, 9);
      cycle(0, 7, 9, 0, 0, 32'd0, 1, 7);
      cycle(0, 7, 9, 1, 7, 32'hA5A50007, 1, 7);
      cycle(0, 7, 9, 0, 0, 32'd0, 0, 0);
      // issue r3 with write-back of r9
      cycle(0, 3, 9, 1, 9, 32'h00000909, 1, 3);
      cycle(0, 3, 9, 0, 0, 32'd0, 1, 11);
      cycle(0, 3, 11, 1, 9, 32'h99999999, 0, 0);
      // reset with count=3 and a write in flight
      cycle(1, 7, 8, 1, 9, 32'h55555555, 0, 0);
      cycle(1, 3, 11, 0, 0, 32'd0, 0, 0);
      cycle(0, 4, 5, 0, 0, 32'd0, 1, 4);
      cycle(0, 4, 4, 0, 0, 32'd0, 0, 0);
      for (int n = 0; n < 600; n++) begin
         cycle(0, rnd_idx(), rnd_idx(), 1'($urandom_range(0, 1)), rnd_idx(), $urandom,
               1'($urandom_range(0, 1)), rnd_idx());
      end
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
